// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } ifetch_state_t;

  typedef struct packed {
    logic [31:0]         pc;
    logic [INSTR_W-1:0]  instr;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Instruction queue storage: DEPTH-entry FIFO of {pc, instr} with flush.
module ifq_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  ifq_entry_t                 push_data,
  input  logic                       pop,
  input  logic                       flush,
  output ifq_entry_t                 head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  ifq_entry_t         mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;

  // Storage needs no reset: count gates every read through id_valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: owns the fetch PC, single-outstanding imem requests and the
// decode-facing instruction queue. Define IFETCH_PERF_CNT_EN for perf counters.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [31:0]         imem_addr,
  input  logic                imem_rvalid,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [INSTR_W-1:0]  id_instr,
  output logic [31:0]         id_pc,
  output logic [31:0]         fetch_cnt,
  output logic [31:0]         flush_cnt
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  ifetch_state_t   state;
  logic [31:0]     fetch_pc;
  logic [31:0]     req_pc;
  logic [31:0]     target_pc;
  logic [CW-1:0]   count;
  logic [CW:0]     in_use;
  logic            outstanding;
  logic            credit;
  logic            push;
  logic            pop;
  ifq_entry_t      push_data;
  ifq_entry_t      head;

  assign target_pc   = redirect_pc & ~32'h3;
  assign outstanding = (state != IDLE);
  assign in_use      = {1'b0, count} + {{CW{1'b0}}, outstanding};
  assign credit      = (in_use < DEPTH_W);

  // Request is combinational so it can issue in the first cycle after reset
  // and be suppressed by a same-cycle redirect.
  assign imem_req  = rst_n && (state == IDLE) && credit && !redirect;
  assign imem_addr = fetch_pc;

  assign push      = (state == WAIT) && imem_rvalid && !redirect;
  assign pop       = id_valid && id_ready && !redirect;
  assign push_data = '{pc: req_pc, instr: imem_rdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      unique case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= target_pc;
          end else if (credit) begin
            state  <= WAIT;
            req_pc <= fetch_pc;
          end
        end
        WAIT: begin
          if (redirect) begin
            fetch_pc <= target_pc;
            state    <= imem_rvalid ? IDLE : DROP;
          end else if (imem_rvalid) begin
            fetch_pc <= fetch_pc + PC_STEP;
            state    <= IDLE;
          end
        end
        DROP: begin
          if (redirect) begin
            fetch_pc <= target_pc;
          end
          if (imem_rvalid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (count)
  );

  assign id_valid = (count != '0);
  assign id_instr = head.instr;
  assign id_pc    = head.pc;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_q;
  logic [31:0] flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_q <= '0;
      flush_q <= '0;
    end else begin
      fetch_q <= fetch_q + 32'(push);
      flush_q <= flush_q + 32'(redirect);
    end
  end

  assign fetch_cnt = fetch_q;
  assign flush_cnt = flush_q;
`else
  assign fetch_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue against a queue-based fetch model.
module tb_ifetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;

  ifetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .fetch_cnt   (fetch_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: fetched-instruction queue plus one in-flight request.
  logic [31:0] q_pc[$];
  logic [31:0] q_ins[$];
  logic [31:0] m_pc;
  logic [31:0] m_req_pc;
  bit          m_out;
  bit          m_drop;
  logic [31:0] m_fetch;
  logic [31:0] m_flush;

  // Memory responder.
  bit          mem_busy;
  logic [31:0] mem_addr;
  int unsigned mem_cnt;
  int unsigned lat_fix;
  bit          stray_en;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h2002_0005;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_pc.delete();
    q_ins.delete();
    m_pc     = RESET_PC;
    m_req_pc = RESET_PC;
    m_out    = 0;
    m_drop   = 0;
    m_fetch  = '0;
    m_flush  = '0;
  endtask

  function automatic logic [31:0] exp_cnt(input logic [31:0] v);
`ifdef IFETCH_PERF_CNT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit ready, input bit do_rst);
    bit          resp;
    bit          real_resp;
    bit          exp_valid;
    bit          exp_req;
    if (do_rst) begin
      rst_n = 1'b0;
      #1;
      model_reset();
      check_eq("rst_req", imem_req, 0);
      check_eq("rst_valid", id_valid, 0);
      check_eq("rst_fcnt", fetch_cnt, 0);
      check_eq("rst_xcnt", flush_cnt, 0);
      rst_n = 1'b1;
      #1;
    end
    real_resp = mem_busy && (mem_cnt == 0);
    resp      = real_resp;
    imem_rdata = real_resp ? word_at(mem_addr) : 32'hDEAD_BEEF;
    if (!mem_busy && stray_en && ($urandom_range(0, 19) == 0)) begin
      resp       = 1;
      imem_rdata = $urandom;
    end
    imem_rvalid = resp;
    redirect    = redir;
    redirect_pc = rpc;
    id_ready    = ready;
    #1;
    exp_valid = (q_pc.size() != 0);
    exp_req   = !m_out && ((q_pc.size() + (m_out ? 1 : 0)) < DEPTH) && !redir;
    check_eq("id_valid", id_valid, exp_valid);
    if (exp_valid) begin
      check_eq("id_pc", id_pc, q_pc[0]);
      check_eq("id_instr", id_instr, q_ins[0]);
    end
    check_eq("imem_req", imem_req, exp_req);
    if (exp_req) check_eq("imem_addr", imem_addr, m_pc);
    check_eq("fetch_cnt", fetch_cnt, exp_cnt(m_fetch));
    check_eq("flush_cnt", flush_cnt, exp_cnt(m_flush));

    if (redir) begin
      q_pc.delete();
      q_ins.delete();
      if (m_out && resp) m_out = 0;
      else if (m_out)    m_drop = 1;
      m_pc = rpc & ~32'h3;
      m_flush++;
    end else begin
      if (exp_valid && ready) begin
        void'(q_pc.pop_front());
        void'(q_ins.pop_front());
      end
      if (m_out && resp) begin
        if (!m_drop) begin
          q_pc.push_back(m_req_pc);
          q_ins.push_back(imem_rdata);
          m_pc = m_pc + 32'd4;
          m_fetch++;
        end
        m_out  = 0;
        m_drop = 0;
      end
      if (exp_req) begin
        m_out    = 1;
        m_drop   = 0;
        m_req_pc = m_pc;
      end
    end

    if (real_resp) mem_busy = 0;
    else if (mem_busy) mem_cnt--;
    if (imem_req) begin
      mem_busy = 1;
      mem_addr = imem_addr;
      mem_cnt  = ((lat_fix != 0) ? lat_fix : $urandom_range(1, 4)) - 1;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    id_ready    = 1'b0;
    mem_busy    = 0;
    mem_addr    = '0;
    mem_cnt     = 0;
    lat_fix     = 1;
    stray_en    = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("init_req", imem_req, 0);
    check_eq("init_valid", id_valid, 0);
    rst_n = 1'b1;

    // First fetch with 1-cycle memory, then fill with decode stalled.
    for (int i = 0; i < 12; i++) step(0, '0, 0, 0);
    check_eq("fill_depth", q_pc.size(), DEPTH);
    for (int i = 0; i < 10; i++) step(0, '0, 1, 0);

    // Redirect while waiting on a slow response.
    lat_fix = 3;
    for (int i = 0; i < 10 && !(m_out && mem_busy && mem_cnt >= 1); i++) step(0, '0, 1, 0);
    check_eq("sync_wait", m_out && mem_busy && mem_cnt >= 1, 1);
    step(1, 32'h0000_0040, 1, 0);
    for (int i = 0; i < 10; i++) step(0, '0, 1, 0);

    // Redirect coincident with the response and a pop.
    lat_fix = 1;
    for (int i = 0; i < 12 && !(q_pc.size() != 0 && mem_busy && mem_cnt == 0); i++) step(0, '0, 0, 0);
    check_eq("sync_coinc", q_pc.size() != 0 && mem_busy && mem_cnt == 0, 1);
    step(1, 32'h0000_0080, 1, 0);
    for (int i = 0; i < 6; i++) step(0, '0, 1, 0);

    // Reset pulse mid-WAIT with a late response.
    lat_fix = 3;
    for (int i = 0; i < 10 && !(m_out && mem_busy && mem_cnt >= 1); i++) step(0, '0, 1, 0);
    check_eq("sync_rst", m_out && mem_busy && mem_cnt >= 1, 1);
    step(0, '0, 1, 1);
    for (int i = 0; i < 10; i++) step(0, '0, 1, 0);

    // PC wrap, with unaligned target bits ignored.
    lat_fix = 1;
    step(1, 32'hFFFF_FFF6, 1, 0);
    for (int i = 0; i < 12; i++) step(0, '0, 1, 0);

    // Randomized traffic.
    lat_fix  = 0;
    stray_en = 1;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 15) == 0), $urandom, ($urandom_range(0, 9) < 7), ($urandom_range(0, 499) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch stage that sits directly upstream of the single-cycle `Processor` decode/execute datapath. It owns the fetch PC, issues requests to instruction memory with a single-outstanding request/valid handshake, and buffers returned instructions with their PCs in a small FIFO. It presents them to decode over a valid/ready interface and flushes on branch redirects (taken `beq`, jumps) signalled by execute.

## Interface
- `DEPTH`, 4: instruction queue entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: fetch PC loaded at reset.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `imem_req`  out  1  one-cycle request pulse; memory always accepts.
- `imem_addr`  out  32  word-aligned fetch address; valid when `imem_req`=1.
- `imem_rvalid`  in  1  response strobe; ≥1 cycle after the request.
- `imem_rdata`  in  32  instruction word; valid when `imem_rvalid`=1.
- `redirect`  in  1  execute requests a fetch redirect this cycle.
- `redirect_pc`  in  32  redirect target, i.e. PC+4+(sext(beq_offset)<<2); bits[1:0] ignored.
- `id_valid`  out  1  queue head holds a valid instruction.
- `id_ready`  in  1  decode accepts the head this cycle.
- `id_instr`  out  32  head instruction.
- `id_pc`  out  32  address of head instruction.
- `fetch_cnt`  out  32  instructions enqueued (see Configuration).
- `flush_cnt`  out  32  redirects taken (see Configuration).

## Operation
- FSM states: IDLE (no request outstanding), WAIT (one outstanding, response kept), DROP (one outstanding, response discarded).
- Credit: request allowed only when `count + outstanding < DEPTH`. The queue can therefore never overflow, and a push never meets a full queue.
- IDLE: `imem_req` = credit && !`redirect`; `imem_addr` = `fetch_pc`. On a request, go to WAIT and latch `req_pc` = `fetch_pc`.
- WAIT, `imem_rvalid` && !`redirect`: push {`req_pc`, `imem_rdata`}, `fetch_pc` += 4, go to IDLE.
- Redirect, any state: flush the queue (count=0), `fetch_pc` = {`redirect_pc`[31:2], 2'b00}.
  - From WAIT without `imem_rvalid` in the same cycle: go to DROP.
  - From WAIT with `imem_rvalid` in the same cycle: discard the data, go to IDLE.
  - From IDLE: no request that cycle; stay in IDLE.
- DROP: on `imem_rvalid`, discard and go to IDLE. A second redirect in DROP only updates `fetch_pc`.
- Pop: `id_valid` && `id_ready` pops the head. A pop is ignored in the same cycle as a redirect (flush wins). Push and pop in the same cycle leave count unchanged.
- `id_valid` = (count != 0). `id_instr`/`id_pc` come from registered queue storage; no combinational path from `imem_rdata` to `id_*`.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- `imem_rvalid` in IDLE is a protocol error and is ignored.

## Timing
- Reset (async assert): `fetch_pc`=`RESET_PC`, state IDLE, count=0, `id_valid`=0, counters=0. `imem_req` is forced 0 while `rst_n`=0.
- With 1-cycle memory: first `imem_req` in cycle 0 after deassertion, `imem_rvalid` in cycle 1, `id_valid` in cycle 2.
- Steady state: one request every 2 cycles (request, response, request ...).
- Redirect in cycle N: `id_valid`=0 in N+1. The request to `redirect_pc` goes out in N+1 if IDLE, or in the cycle after the dropped response.
- Reset asserted mid-operation: all state clears immediately. A late `imem_rvalid` after reset is ignored (state is IDLE).

## Configuration
- `IFETCH_PERF_CNT_EN` defined:
  - `fetch_cnt` increments on each push.
  - `flush_cnt` increments on each cycle with `redirect`=1.
  - Both are 32-bit and wrap.
- Not defined: both counter ports are tied to 0 and no counter flops are built.

## Structure
- Package `ifetch_pkg` holds:
  - FSM state enum `ifetch_state_t` (IDLE/WAIT/DROP).
  - `INSTR_W`=32.
  - `PC_STEP`=4.
  - Packed struct `ifq_entry_t` {pc, instr}.
- Sub-module `ifq_fifo`: parameterised `DEPTH` FIFO of `ifq_entry_t` with push, pop, flush and count ports; pointers wrap modulo `DEPTH`.
- The top level holds the FSM, `fetch_pc`, credit logic and the optional counters.

## Test plan
- Reset release, 1-cycle memory returning 32'h2002_0005 at 0 → `id_valid` in cycle 2 with `id_pc`=0 and `id_instr`=32'h2002_0005; next `imem_addr`=4.
- `id_ready`=0 with 1-cycle memory → exactly 4 entries (PCs 0, 4, 8, C). `imem_req` stays 0 while count+outstanding=4. Releasing `id_ready` pops in order and fetching resumes at 32'h10.
- Redirect to 32'h40 while WAIT with 3-cycle latency → queue empties next cycle, the stale response is dropped, and the next `imem_addr`=32'h40.
- Redirect coincident with `imem_rvalid` and a pop → data discarded, no pop, count=0, and the next request goes to `redirect_pc`.
- `rst_n` pulsed low mid-WAIT, then memory returns late data → no push, and a fresh request goes to `RESET_PC`.
- With `IFETCH_PERF_CNT_EN`: 10 fetches and 2 redirects → `fetch_cnt`=10 and `flush_cnt`=2. Without the macro both read 0.
